// File: rtl/func_sel_timer.sv
// -----------------------------------------------------------------------------
// func_sel_timer
//
// Function / microcode-ROM select timer. On an accepted start request it drives
// one of N_SEL select lines high for a programmable number of clock cycles,
// then drops it and pulses done for one cycle. The duration is held in a
// runtime-loadable length register that is snapshotted when a run starts, so
// reloading it mid-run only affects the next run.
//
// Parameters
//   CNT_W       width of the cycle counter and of the length register
//   DEFAULT_LEN length register value after Clear (must be < 2**CNT_W)
//   N_SEL       number of select outputs (>= 2)
//   FSEL_W      width of func (>= $clog2(N_SEL))
//   RETRIG      1: a start while running restarts the timer on the new channel
//               0: a start while running is silently ignored
//
// Ports
//   Clk          clock, all logic on the rising edge
//   Clear        synchronous active-high reset
//   start_timer  start request, sampled every edge
//   func         channel index, captured with an accepted start
//   len_in       new duration in cycles
//   len_load     writes len_in into the length register (any state)
//   abort        cancels a running timer; also blocks a start in IDLE
//   ROMsel       registered select, one-hot or zero
//   busy         high while the timer is running
//   done         one-cycle pulse after normal completion (or zero-length start)
//   err          one-cycle pulse on a start with an out-of-range func
//   count        current cycle count within the run (debug)
// -----------------------------------------------------------------------------
module func_sel_timer #(
  parameter int CNT_W       = 4,
  parameter int DEFAULT_LEN = 13,
  parameter int N_SEL       = 4,
  parameter int FSEL_W      = 2,
  parameter bit RETRIG      = 1'b0
) (
  input  logic              Clk,
  input  logic              Clear,
  input  logic              start_timer,
  input  logic [FSEL_W-1:0] func,
  input  logic [CNT_W-1:0]  len_in,
  input  logic              len_load,
  input  logic              abort,
  output logic [N_SEL-1:0]  ROMsel,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [CNT_W-1:0]  count
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  run_len_q, run_len_d;
  logic [CNT_W-1:0]  len_reg_q;
  logic [N_SEL-1:0]  sel_q, sel_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              func_valid;
  logic              start_req;
  logic              retrig_req;
  logic              last_cycle;
  logic [N_SEL-1:0]  func_onehot;

  // When every encodable func value names a real channel the range check is
  // trivially true; resolving it at elaboration keeps the comparison from
  // degenerating into a constant compare.
  if (N_SEL >= (1 << FSEL_W)) begin : g_func_all_valid
    assign func_valid = 1'b1;
  end else begin : g_func_range_check
    assign func_valid = (func < FSEL_W'(N_SEL));
  end

  // abort outranks start everywhere, including in IDLE.
  assign start_req   = start_timer && !abort;
  assign retrig_req  = RETRIG && start_req;
  assign func_onehot = N_SEL'(1) << func;

  // run_len is never zero in RUN (zero-length starts never enter RUN), so
  // run_len - 1 cannot underflow and count never wraps.
  assign last_cycle  = (count_q == (run_len_q - CNT_W'(1)));

  // Length register: Clear restores the default, otherwise len_load writes it
  // in any state. A start in the same cycle sees the old value because the
  // next-state logic reads len_reg_q, the pre-edge contents.
  always_ff @(posedge Clk) begin
    if (Clear) begin
      len_reg_q <= CNT_W'(DEFAULT_LEN);
    end else if (len_load) begin
      len_reg_q <= len_in;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    // NOTE: every signal driven here gets a default first; a path that leaves
    // one unassigned would otherwise infer a latch.
    state_d   = state_q;
    count_d   = count_q;
    run_len_d = run_len_q;
    sel_d     = sel_q;
    done_d    = 1'b0;
    err_d     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start_req) begin
          if (!func_valid) begin
            err_d = 1'b1;
          end else if (len_reg_q == '0) begin
            // Zero-length request completes immediately without selecting.
            done_d = 1'b1;
          end else begin
            state_d   = S_RUN;
            count_d   = '0;
            run_len_d = len_reg_q;
            sel_d     = func_onehot;
          end
        end
      end

      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
          count_d = '0;
          sel_d   = '0;
        end else if (retrig_req && func_valid) begin
          if (len_reg_q == '0) begin
            // Retrigger into a zero-length run: treat as an immediate,
            // normal completion rather than entering RUN with nothing to time.
            state_d = S_IDLE;
            count_d = '0;
            sel_d   = '0;
            done_d  = 1'b1;
          end else begin
            // Channel switch happens at this edge with no idle gap.
            count_d   = '0;
            run_len_d = len_reg_q;
            sel_d     = func_onehot;
          end
        end else if (last_cycle) begin
          // A rejected retrigger landing on the final cycle raises no err so
          // that done and err never coincide; the run is ending anyway.
          state_d = S_IDLE;
          count_d = '0;
          sel_d   = '0;
          done_d  = 1'b1;
        end else begin
          count_d = count_q + CNT_W'(1);
          // Only an out-of-range retrigger reaches here with retrig_req set.
          err_d   = retrig_req;
        end
      end

      default: begin
        state_d = S_IDLE;
        count_d = '0;
        sel_d   = '0;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    if (Clear) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      run_len_q <= '0;
      sel_q     <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      run_len_q <= run_len_d;
      sel_q     <= sel_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign ROMsel = sel_q;
  assign busy   = (state_q == S_RUN);
  assign done   = done_q;
  assign err    = err_q;
  assign count  = count_q;

endmodule
